// File: rtl/ocx_tlx_xmt_framer_if.sv
// ocx_tlx_xmt_framer_if
//   Groups the TLX transmit-queue handshakes and the DLX flit interface of the
//   transmit framer.
//   slave  : the framer side (takes packets/data, drives flits to the DLX).
//   master : the traffic source / DLX side.
//   Signals:
//     xmt_rsp_*     56-bit response packet + data-flit count (valid/ready)
//     xmt_credit_*  56-bit credit-return packet (valid/ready)
//     xmt_data_*    512-bit data flit + bad-data indicator (valid/ready)
//     dlx_tlx_flit_credit      one-cycle flit credit return from the DLX
//     tlx_dlx_flit_valid/flit  registered flit to the DLX
//     tlx_dlx_credit_overflow  sticky credit overflow flag
interface ocx_tlx_xmt_framer_if;
  logic         xmt_rsp_valid;
  logic [55:0]  xmt_rsp_info;
  logic [1:0]   xmt_rsp_dlen;
  logic         xmt_rsp_ready;
  logic         xmt_credit_v;
  logic [55:0]  xmt_credit_info;
  logic         xmt_credit_ready;
  logic         xmt_data_valid;
  logic [511:0] xmt_data_bus;
  logic         xmt_data_bdi;
  logic         xmt_data_ready;
  logic         dlx_tlx_flit_credit;
  logic         tlx_dlx_flit_valid;
  logic [511:0] tlx_dlx_flit;
  logic         tlx_dlx_credit_overflow;

  modport slave (
    input  xmt_rsp_valid, xmt_rsp_info, xmt_rsp_dlen,
    output xmt_rsp_ready,
    input  xmt_credit_v, xmt_credit_info,
    output xmt_credit_ready,
    input  xmt_data_valid, xmt_data_bus, xmt_data_bdi,
    output xmt_data_ready,
    input  dlx_tlx_flit_credit,
    output tlx_dlx_flit_valid, tlx_dlx_flit, tlx_dlx_credit_overflow
  );

  modport master (
    output xmt_rsp_valid, xmt_rsp_info, xmt_rsp_dlen,
    input  xmt_rsp_ready,
    output xmt_credit_v, xmt_credit_info,
    input  xmt_credit_ready,
    output xmt_data_valid, xmt_data_bus, xmt_data_bdi,
    input  xmt_data_ready,
    output dlx_tlx_flit_credit,
    input  tlx_dlx_flit_valid, tlx_dlx_flit, tlx_dlx_credit_overflow
  );
endinterface

// File: rtl/ocx_tlx_xmt_framer.sv
// ocx_tlx_xmt_framer
//   Transmit-side TL framer. Packs up to MAX_SLOTS response packets (plus an
//   optional credit-return packet) into a 512-bit control flit, then forwards
//   the data flits owed by those packets, all under DLX flit-credit control.
//   Ports:
//     tlx_clk  clock
//     reset_n  asynchronous active-low reset
//     bus      ocx_tlx_xmt_framer_if.slave (packet, data and DLX flit signals)
module ocx_tlx_xmt_framer #(
  parameter int MAX_SLOTS    = 4,
  parameter int MAX_RUN      = 8,
  parameter int FILL_TIMEOUT = 16,
  parameter int CREDIT_MAX   = 15
) (
  input  logic                   tlx_clk,
  input  logic                   reset_n,
  ocx_tlx_xmt_framer_if.slave    bus
);

  localparam int SCNT_W = $clog2(MAX_SLOTS + 1);
  localparam int SIDX_W = (MAX_SLOTS > 1) ? $clog2(MAX_SLOTS) : 1;
  localparam int TMR_W  = $clog2(FILL_TIMEOUT + 1);
  localparam logic [SCNT_W-1:0] SLOTS_L = SCNT_W'(MAX_SLOTS);
  localparam logic [4:0]        RUN_L   = 5'(MAX_RUN);
  localparam logic [TMR_W-1:0]  TMR_L   = TMR_W'(FILL_TIMEOUT);
  localparam logic [3:0]        CRED_L  = 4'(CREDIT_MAX);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_SEND_CTL, ST_SEND_DATA} state_t;

  state_t              r_state, w_state_nxt;
  logic [SCNT_W-1:0]   r_slots;
  logic [55:0]         r_slot [MAX_SLOTS];
  logic [3:0]          r_run, r_dcnt, r_credit;
  logic [TMR_W-1:0]    r_timer;
  logic [7:0]          r_bdi;
  logic                r_overflow, r_flit_valid;
  logic [511:0]        r_flit;

  logic [1:0]   w_dlen;
  logic         w_slot_free, w_run_ok;
  logic         w_rsp_rdy, w_data_rdy, w_rsp_acc, w_ctl_send, w_data_acc, w_send;
  logic [511:0] w_ctl_flit;

  assign w_dlen      = (bus.xmt_rsp_dlen == 2'd3) ? 2'd2 : bus.xmt_rsp_dlen;
  assign w_slot_free = r_slots < SLOTS_L;
  assign w_run_ok    = ({1'b0, r_run} + {3'b000, w_dlen}) <= RUN_L;
  assign w_send      = w_ctl_send | w_data_acc;

  always_comb begin
    w_state_nxt = r_state;
    w_rsp_rdy   = 1'b0;
    w_data_rdy  = 1'b0;
    w_rsp_acc   = 1'b0;
    w_ctl_send  = 1'b0;
    w_data_acc  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_rsp_rdy = 1'b1;
        if (bus.xmt_rsp_valid) begin
          w_rsp_acc   = 1'b1;
          w_state_nxt = ST_FILL;
        end else if (bus.xmt_credit_v) begin
          w_state_nxt = ST_SEND_CTL;
        end
      end
      ST_FILL: begin
        w_rsp_rdy = w_slot_free & w_run_ok;
        if (bus.xmt_rsp_valid && w_rsp_rdy) begin
          w_rsp_acc = 1'b1;
          if (r_slots + SCNT_W'(1) == SLOTS_L) w_state_nxt = ST_SEND_CTL;
        end else if (!w_slot_free || bus.xmt_rsp_valid || r_timer == TMR_L) begin
          // a valid packet reaching here was refused by the run-length limit
          w_state_nxt = ST_SEND_CTL;
        end
      end
      ST_SEND_CTL: begin
        if (r_credit != 4'd0) begin
          w_ctl_send  = 1'b1;
          w_state_nxt = (r_run != 4'd0) ? ST_SEND_DATA : ST_IDLE;
        end
      end
      ST_SEND_DATA: begin
        w_data_rdy = (r_credit != 4'd0);
        if (bus.xmt_data_valid && w_data_rdy) begin
          w_data_acc = 1'b1;
          if (r_dcnt + 4'd1 == r_run) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Control flit image; unfilled slots and unused fields stay zero.
  always_comb begin
    w_ctl_flit = '0;
    for (int k = 0; k < MAX_SLOTS; k++) begin
      if (SCNT_W'(k) < r_slots) begin
        w_ctl_flit[56*k +: 56] = r_slot[k];
        w_ctl_flit[448+k]      = 1'b1;
      end
    end
    if (bus.xmt_credit_v) begin
      w_ctl_flit[279:224] = bus.xmt_credit_info;
      w_ctl_flit[452]     = 1'b1;
    end
    w_ctl_flit[459:456] = r_run;
    w_ctl_flit[467:460] = r_bdi;
    w_ctl_flit[473:468] = 6'h01;
  end

  // Ready is forced low while reset is held so every output reads 0 in reset.
  assign bus.xmt_rsp_ready           = reset_n & w_rsp_rdy;
  assign bus.xmt_data_ready          = w_data_rdy;
  assign bus.xmt_credit_ready        = w_ctl_send & bus.xmt_credit_v;
  assign bus.tlx_dlx_flit_valid      = r_flit_valid;
  assign bus.tlx_dlx_flit            = r_flit;
  assign bus.tlx_dlx_credit_overflow = r_overflow;

  always_ff @(posedge tlx_clk) begin
    if (w_rsp_acc) r_slot[r_slots[SIDX_W-1:0]] <= bus.xmt_rsp_info;
  end

  always_ff @(posedge tlx_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_slots      <= '0;
      r_run        <= '0;
      r_dcnt       <= '0;
      r_timer      <= '0;
      r_bdi        <= '0;
      r_credit     <= '0;
      r_overflow   <= 1'b0;
      r_flit_valid <= 1'b0;
      r_flit       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_flit_valid <= w_send;
      if (w_ctl_send)      r_flit <= w_ctl_flit;
      else if (w_data_acc) r_flit <= bus.xmt_data_bus;

      if (w_rsp_acc) begin
        r_slots <= r_slots + SCNT_W'(1);
        r_run   <= r_run + {2'b00, w_dlen};
      end else if (w_ctl_send) begin
        r_slots <= '0;
      end

      if (w_rsp_acc || w_ctl_send) r_timer <= '0;
      else if (r_state == ST_FILL) r_timer <= r_timer + TMR_W'(1);

      // The BDI gathered during a run rides in the next control flit, which
      // also clears it for the run that follows.
      if (w_ctl_send) begin
        r_bdi  <= '0;
        r_dcnt <= '0;
      end else if (w_data_acc) begin
        if (!r_dcnt[3]) r_bdi[r_dcnt[2:0]] <= bus.xmt_data_bdi;
        if (r_dcnt + 4'd1 == r_run) begin
          r_dcnt <= '0;
          r_run  <= '0;
        end else begin
          r_dcnt <= r_dcnt + 4'd1;
        end
      end

      // A returned credit and a sent flit in the same cycle cancel out.
      if (bus.dlx_tlx_flit_credit && !w_send) begin
        if (r_credit == CRED_L) r_overflow <= 1'b1;
        else                    r_credit   <= r_credit + 4'd1;
      end else if (w_send && !bus.dlx_tlx_flit_credit) begin
        r_credit <= r_credit - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_ocx_tlx_xmt_framer.sv
module tb_ocx_tlx_xmt_framer;
  logic tlx_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 tlx_clk = ~tlx_clk;

  ocx_tlx_xmt_framer_if bus();

  ocx_tlx_xmt_framer #(.MAX_SLOTS(4), .MAX_RUN(8), .FILL_TIMEOUT(16), .CREDIT_MAX(15)) dut (
    .tlx_clk (tlx_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int cr_cnt = 0;
  int acc_cyc = 0;
  int last_cyc = 0;
  logic [511:0] q_flit[$];
  int           q_cyc[$];

  localparam logic [55:0] CI1 = 56'hC0FFEE_0000_0001;
  localparam logic [55:0] CI2 = 56'h00ABCD_0000_0002;

  always @(posedge tlx_clk) cyc <= cyc + 1;

  always @(negedge tlx_clk) begin
    if (bus.tlx_dlx_flit_valid) begin
      q_flit.push_back(bus.tlx_dlx_flit);
      q_cyc.push_back(cyc);
    end
    if (bus.xmt_credit_ready) cr_cnt <= cr_cnt + 1;
  end

  function automatic logic [511:0] mk(input logic [55:0] s0, input logic [55:0] s1,
                                      input logic [55:0] s2, input logic [55:0] s3,
                                      input logic [3:0] m, input logic [55:0] ci, input logic cv,
                                      input logic [3:0] run, input logic [7:0] bdi);
    logic [511:0] f;
    f = '0;
    f[55:0] = s0; f[111:56] = s1; f[167:112] = s2; f[223:168] = s3;
    f[279:224] = ci; f[451:448] = m; f[452] = cv;
    f[459:456] = run; f[467:460] = bdi; f[473:468] = 6'h01;
    return f;
  endfunction

  function automatic logic [511:0] dpat(input logic [7:0] k);
    return {64{k}};
  endfunction

  task automatic step();
    @(negedge tlx_clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [55:0] info, input logic [1:0] dl, input string tag);
    bit ok;
    ok = 1'b0;
    bus.xmt_rsp_valid = 1'b1; bus.xmt_rsp_info = info; bus.xmt_rsp_dlen = dl;
    for (int i = 0; i < 60 && !ok; i++) begin
      #1;
      if (bus.xmt_rsp_ready) begin ok = 1'b1; acc_cyc = cyc + 1; end
      step();
    end
    bus.xmt_rsp_valid = 1'b0;
    n_cmp++;
    assert (ok) else begin n_err++; $error("FAIL %s: packet accepted=%b required 1", tag, ok); end
  endtask

  task automatic push_data(input logic [511:0] d, input logic bdi, input string tag);
    bit ok;
    ok = 1'b0;
    bus.xmt_data_valid = 1'b1; bus.xmt_data_bus = d; bus.xmt_data_bdi = bdi;
    for (int i = 0; i < 60 && !ok; i++) begin
      #1;
      if (bus.xmt_data_ready) ok = 1'b1;
      step();
    end
    bus.xmt_data_valid = 1'b0; bus.xmt_data_bdi = 1'b0;
    n_cmp++;
    assert (ok) else begin n_err++; $error("FAIL %s: data accepted=%b required 1", tag, ok); end
  endtask

  task automatic expect_flit(input string tag, input logic [511:0] exp, input int budget);
    int n;
    logic [511:0] f;
    n = 0;
    while (q_flit.size() == 0 && n < budget) begin step(); n++; end
    n_cmp++;
    assert (q_flit.size() != 0) else begin
      n_err++;
      $error("FAIL %s: no flit within %0d cycles, required one", tag, budget);
    end
    if (q_flit.size() != 0) begin
      f = q_flit.pop_front();
      last_cyc = q_cyc.pop_front();
      check(tag, f, exp);
    end
  endtask

  task automatic expect_none(input string tag, input int cycles);
    int sz;
    repeat (cycles) step();
    sz = q_flit.size();
    n_cmp++;
    assert (sz == 0) else begin
      n_err++;
      $error("FAIL %s: %0d flits emitted, required 0", tag, sz);
    end
    q_flit.delete();
    q_cyc.delete();
  endtask

  task automatic credit_pulse(input int n);
    bus.dlx_tlx_flit_credit = 1'b1;
    repeat (n) step();
    bus.dlx_tlx_flit_credit = 1'b0;
  endtask

  initial begin
    bus.xmt_rsp_valid = 1'b0; bus.xmt_rsp_info = '0; bus.xmt_rsp_dlen = '0;
    bus.xmt_credit_v = 1'b0; bus.xmt_credit_info = '0;
    bus.xmt_data_valid = 1'b0; bus.xmt_data_bus = '0; bus.xmt_data_bdi = 1'b0;
    bus.dlx_tlx_flit_credit = 1'b0;

    // reset state
    #1;
    check("rst_flit_valid", 512'(bus.tlx_dlx_flit_valid), 512'(0));
    check("rst_flit", bus.tlx_dlx_flit, '0);
    check("rst_overflow", 512'(bus.tlx_dlx_credit_overflow), 512'(0));
    check("rst_rsp_ready", 512'(bus.xmt_rsp_ready), 512'(0));
    check("rst_data_ready", 512'(bus.xmt_data_ready), 512'(0));
    step(); step();
    reset_n = 1'b1;
    step();
    check("idle_rsp_ready", 512'(bus.xmt_rsp_ready), 512'(1));

    // no credit -> no flit, then one credit releases it
    push(56'hA5, 2'd0, "t1_push");
    expect_none("t1_no_credit", 30);
    credit_pulse(1);
    expect_flit("t1_ctl", mk(56'hA5, 0, 0, 0, 4'b0001, 0, 1'b0, 4'd0, 8'h00), 4);

    // four packets back-to-back; nothing leaves while the counter is 0
    push(56'h11, 2'd1, "t2_p0");
    push(56'h22, 2'd0, "t2_p1");
    push(56'h33, 2'd2, "t2_p2");
    push(56'h44, 2'd0, "t2_p3");
    expect_none("t1_counter_back_to_0", 5);
    credit_pulse(4);
    expect_flit("t2_ctl", mk(56'h11, 56'h22, 56'h33, 56'h44, 4'b1111, 0, 1'b0, 4'd3, 8'h00), 1);
    push_data(dpat(8'hD1), 1'b0, "t2_d0");
    push_data(dpat(8'hD2), 1'b0, "t2_d1");
    push_data(dpat(8'hD3), 1'b0, "t2_d2");
    #1;
    check("t2_data_ready_drop", 512'(bus.xmt_data_ready), 512'(0));
    expect_flit("t2_data0", dpat(8'hD1), 3);
    expect_flit("t2_data1", dpat(8'hD2), 3);
    expect_flit("t2_data2", dpat(8'hD3), 3);

    // MAX_RUN limit: 5th dlen=2 packet is held until the first run is done
    push(56'h51, 2'd2, "t3_p0");
    push(56'h52, 2'd2, "t3_p1");
    push(56'h53, 2'd3, "t3_p2");
    push(56'h54, 2'd2, "t3_p3");
    bus.xmt_rsp_valid = 1'b1; bus.xmt_rsp_info = 56'h55; bus.xmt_rsp_dlen = 2'd2;
    credit_pulse(12);
    check("t3_held_ready", 512'(bus.xmt_rsp_ready), 512'(0));
    expect_flit("t3_ctl1", mk(56'h51, 56'h52, 56'h53, 56'h54, 4'b1111, 0, 1'b0, 4'd8, 8'h00), 1);
    for (int i = 0; i < 8; i++) push_data(dpat(8'(8'h30 + i)), (i == 0 || i == 7), "t3_data_push");
    check("t3_idle_ready", 512'(bus.xmt_rsp_ready), 512'(1));
    step();
    bus.xmt_rsp_valid = 1'b0;
    for (int i = 0; i < 8; i++) expect_flit("t3_data", dpat(8'(8'h30 + i)), 2);
    expect_flit("t3_ctl2", mk(56'h55, 0, 0, 0, 4'b0001, 0, 1'b0, 4'd2, 8'h81), 25);

    // run of 2 with the second flit bad
    push_data(dpat(8'h41), 1'b0, "t4_d0");
    push_data(dpat(8'h42), 1'b1, "t4_d1");
    expect_flit("t4_data0", dpat(8'h41), 2);
    expect_flit("t4_data1", dpat(8'h42), 2);
    credit_pulse(3);
    push(56'h66, 2'd0, "t4_p");
    expect_flit("t4_ctl_bdi", mk(56'h66, 0, 0, 0, 4'b0001, 0, 1'b0, 4'd0, 8'h02), 25);
    bus.xmt_credit_v = 1'b1; bus.xmt_credit_info = CI1;
    push(56'h77, 2'd0, "t4_p2");
    expect_flit("t4_ctl_bdi_clr", mk(56'h77, 0, 0, 0, 4'b0001, CI1, 1'b1, 4'd0, 8'h00), 25);
    bus.xmt_credit_v = 1'b0;
    check("t4_credit_ready_cnt", 512'(cr_cnt), 512'(1));

    // credit-return packet alone
    bus.xmt_credit_v = 1'b1; bus.xmt_credit_info = CI2;
    expect_flit("t4_credit_only", mk(0, 0, 0, 0, 4'b0000, CI2, 1'b1, 4'd0, 8'h00), 6);
    bus.xmt_credit_v = 1'b0;
    check("t4_credit_ready_cnt2", 512'(cr_cnt), 512'(2));

    // pulse coincident with a send at counter 1 leaves it at 1
    credit_pulse(1);
    push(56'h88, 2'd0, "t5_p0");
    for (int i = 0; i < 40 && cyc < acc_cyc + 17; i++) step();
    credit_pulse(1);
    expect_flit("t5_ctl0", mk(56'h88, 0, 0, 0, 4'b0001, 0, 1'b0, 4'd0, 8'h00), 3);
    check("t5_latency", 512'(last_cyc - acc_cyc), 512'(18));
    push(56'h99, 2'd0, "t5_p1");
    expect_flit("t5_ctl1", mk(56'h99, 0, 0, 0, 4'b0001, 0, 1'b0, 4'd0, 8'h00), 25);
    push(56'hAA, 2'd0, "t5_p2");
    expect_none("t5_counter_empty", 30);
    credit_pulse(1);
    expect_flit("t5_ctl2", mk(56'hAA, 0, 0, 0, 4'b0001, 0, 1'b0, 4'd0, 8'h00), 4);

    // overflow
    credit_pulse(15);
    check("t6_no_overflow_at_15", 512'(bus.tlx_dlx_credit_overflow), 512'(0));
    credit_pulse(1);
    check("t6_overflow", 512'(bus.tlx_dlx_credit_overflow), 512'(1));
    repeat (5) step();
    check("t6_overflow_sticky", 512'(bus.tlx_dlx_credit_overflow), 512'(1));

    // reset in the middle of a data run
    push(56'hBB, 2'd2, "t7_p");
    expect_flit("t7_ctl", mk(56'hBB, 0, 0, 0, 4'b0001, 0, 1'b0, 4'd2, 8'h00), 25);
    push_data(dpat(8'hE1), 1'b0, "t7_d0");
    expect_flit("t7_data0", dpat(8'hE1), 2);
    reset_n = 1'b0;
    #1;
    check("t7_rst_flit_valid", 512'(bus.tlx_dlx_flit_valid), 512'(0));
    check("t7_rst_flit", bus.tlx_dlx_flit, '0);
    check("t7_rst_overflow", 512'(bus.tlx_dlx_credit_overflow), 512'(0));
    check("t7_rst_data_ready", 512'(bus.xmt_data_ready), 512'(0));
    step(); step();
    reset_n = 1'b1;
    step();
    check("t7_idle_ready", 512'(bus.xmt_rsp_ready), 512'(1));
    bus.xmt_data_valid = 1'b1; bus.xmt_data_bus = dpat(8'hE2);
    #1;
    check("t7_no_data_ready", 512'(bus.xmt_data_ready), 512'(0));
    expect_none("t7_no_residual", 10);
    bus.xmt_data_valid = 1'b0;
    credit_pulse(1);
    expect_none("t7_idle_no_flit", 3);
    push(56'hCC, 2'd0, "t7_p2");
    expect_flit("t7_after_reset", mk(56'hCC, 0, 0, 0, 4'b0001, 0, 1'b0, 4'd0, 8'h00), 25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ocx_tlx_xmt_framer.md
Name: ocx_tlx_xmt_framer

Overview:
Transmit-side TL framer. Accepts 56-bit response packets, each with optional 64B data, plus credit-return packets from the TLX transmit queues. Packs them into 512-bit control flits, each followed by its data-flit run, and issues flits to the DLX under DLX flit-credit flow control. It is the outbound counterpart of the receive parse path: its control flits carry the run-length, template and bad-data fields that the receive parser decodes.

Parameters:
MAX_SLOTS, 4, max response packets per control flit (1..4)
MAX_RUN, 8, max data flits following one control flit (1..15)
FILL_TIMEOUT, 16, cycles to wait for more packets before closing a partial flit (>=1)
CREDIT_MAX, 15, max DLX flit credits held (fits 4-bit counter)

Ports:
tlx_clk  in  1  clock
reset_n  in  1  async active-low reset
xmt_rsp_valid  in  1  response packet offered
xmt_rsp_info  in  56  response packet
xmt_rsp_dlen  in  2  data flits owed by the packet (0..2; 3 illegal, treated as 2)
xmt_rsp_ready  out  1  packet accepted when valid&ready
xmt_credit_v  in  1  credit-return packet offered
xmt_credit_info  in  56  credit-return packet
xmt_credit_ready  out  1  credit packet accepted when valid&ready
xmt_data_valid  in  1  data flit offered
xmt_data_bus  in  512  data flit
xmt_data_bdi  in  1  data flit is bad
xmt_data_ready  out  1  data flit accepted
dlx_tlx_flit_credit  in  1  one-cycle pulse: DLX returns one flit credit
tlx_dlx_flit_valid  out  1  flit on bus this cycle
tlx_dlx_flit  out  512  flit
tlx_dlx_credit_overflow  out  1  sticky: credit pulse arrived with counter at CREDIT_MAX

Behaviour:
- Reset: all outputs 0. FSM is IDLE; credit counter, slot count, run count, timer and BDI accumulator are 0. An async reset mid-flit abandons the flit; nothing is emitted for it after reset.
- Credit counter (4b): +1 on dlx_tlx_flit_credit, -1 per flit sent. Both in the same cycle: no change. A pulse at CREDIT_MAX does not increment and sets tlx_dlx_credit_overflow.
- A flit is sent only when credit>0. Every emitted flit has tlx_dlx_flit_valid=1 for exactly one cycle, driven from a register.
- Control flit layout:
  - slot k (k<MAX_SLOTS) at [56k+55:56k]
  - credit-return packet at [279:224] (0 if none)
  - slot-valid mask [451:448]; credit valid [452]
  - run length [459:456] = total data flits following this flit
  - BDI of the previous run [467:460], bit i = data flit i bad
  - template [473:468] = 6'h01
  - all other bits 0
- FSM states:
  - IDLE: xmt_rsp_ready=1. An accepted packet goes to slot 0 and the FSM moves to FILL; the timer is cleared.
  - FILL: xmt_rsp_ready=1 unless the slots are full or run+dlen of the offered packet would exceed MAX_RUN (the packet is then held, not accepted). Each accepted packet fills the next slot and adds its dlen to the run; the timer is cleared.
  - FILL -> SEND_CTL when: slots==MAX_SLOTS, or the offered packet is blocked by the MAX_RUN check, or the timer reaches FILL_TIMEOUT.
  - IDLE with only a credit packet pending also goes to SEND_CTL (zero slots).
  - xmt_credit_ready pulses the cycle the control flit is sent, if xmt_credit_v is high; the credit packet is sampled at that point.
  - SEND_CTL: waits for credit>0, emits the control flit. Goes to SEND_DATA if run>0, else IDLE.
  - SEND_DATA: xmt_data_ready = credit>0 and the output register is free. Each accepted data flit is emitted the next cycle and its bdi is recorded at bit index = position in run. After run flits the FSM goes to IDLE; the BDI accumulator is carried into the next control flit, then cleared.
- Data flits belong to the slots of the preceding control flit, in slot order.
- No packet is accepted in SEND_CTL/SEND_DATA.
- Latency: with credit available, a single packet with dlen=0 is emitted FILL_TIMEOUT+2 cycles after acceptance.

Test Plan:
- Credit=0, one packet 56'hA5, dlen=0 → no flit. After one credit pulse → control flit: slot0=A5, mask=4'b0001, run=0, template=01; counter returns to 0.
- 4 credits; 4 packets back-to-back, dlen=1,0,2,0 → control flit: mask=4'b1111, run=3, emitted without timeout. Then 3 data flits in order; xmt_data_ready drops after the 3rd.
- MAX_RUN=8; packets with dlen 2,2,2,2,2 → first flit run=8 with 4 slots. The 5th packet is held until IDLE, then sent in a second flit with run=2.
- Run of 2 with the 2nd data flit bdi=1 → next control flit BDI field=8'b00000010; the flit after that has BDI=0.
- Credit pulse and flit send in the same cycle with counter=1 → counter stays 1. 16 pulses from 0 → counter=15, overflow=1 and sticky.
- reset_n low during SEND_DATA (1 of 2 flits sent) → outputs 0 immediately. After release, IDLE with counter 0 and no residual data flit.
